// File: rtl/mem2p_arbiter_if.sv
// Client-side request/response bundle for mem2p_arbiter: write port, read
// port and the read-response stream with valid/ready backpressure.
interface mem2p_arbiter_if #(
    parameter int G_DATAWIDTH = 32,
    parameter int G_ADDRWIDTH = 10,
    parameter int G_WEWIDTH   = 4
);
    logic                   wr_valid;
    logic                   wr_ready;
    logic [G_ADDRWIDTH-1:0] waddr;
    logic [G_DATAWIDTH-1:0] wdata;
    logic [G_WEWIDTH-1:0]   wstrb;
    logic                   rd_valid;
    logic                   rd_ready;
    logic [G_ADDRWIDTH-1:0] raddr;
    logic [G_DATAWIDTH-1:0] rdata;
    logic                   rvalid;
    logic                   rready;

    modport master (
        output wr_valid, waddr, wdata, wstrb, rd_valid, raddr, rready,
        input  wr_ready, rd_ready, rdata, rvalid
    );

    modport slave (
        input  wr_valid, waddr, wdata, wstrb, rd_valid, raddr, rready,
        output wr_ready, rd_ready, rdata, rvalid
    );
endinterface

// File: rtl/mem2p_arbiter.sv
// Shares the write and read ports of a two-port block RAM between two clients,
// with independent round-robin arbitration and per-client 2-entry response FIFOs.
module mem2p_arbiter #(
    parameter int G_DATAWIDTH = 32,
    parameter int G_MEMDEPTH  = 1024,
    parameter int G_ADDRWIDTH = $clog2(G_MEMDEPTH),
    parameter int G_WEWIDTH   = ((G_DATAWIDTH - 1) / 8) + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    mem2p_arbiter_if.slave         rq0,
    mem2p_arbiter_if.slave         rq1,
    output logic                   mem_wr,
    output logic [G_ADDRWIDTH-1:0] mem_waddr,
    output logic [G_DATAWIDTH-1:0] mem_wdata,
    output logic [G_WEWIDTH-1:0]   mem_wstrb,
    output logic                   mem_rd,
    output logic [G_ADDRWIDTH-1:0] mem_raddr,
    input  logic [G_DATAWIDTH-1:0] mem_rdata
);

    logic [1:0] wr_req, rd_req, wr_gnt, rd_gnt, rd_pop, fifo_push;
    logic       wptr, rptr;
    logic       tag_valid, tag_id;
    logic [1:0] credit [2];

    logic [1:0]             head_valid, tail_valid;
    logic [G_DATAWIDTH-1:0] head_data [2];
    logic [G_DATAWIDTH-1:0] tail_data [2];

    // On a tie the client that was not granted last wins; otherwise the lone requester.
    function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic last);
        rr_pick = req;
        if (req == 2'b11) rr_pick = last ? 2'b01 : 2'b10;
    endfunction

    assign wr_req = {rq1.wr_valid, rq0.wr_valid};
    assign rd_pop = {rq1.rready & head_valid[1], rq0.rready & head_valid[0]};

    // A pop in the same cycle frees a credit, so a full client stays at full rate.
    assign rd_req[0] = rq0.rd_valid && ((credit[0] < 2'd2) || rd_pop[0]);
    assign rd_req[1] = rq1.rd_valid && ((credit[1] < 2'd2) || rd_pop[1]);

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        wr_gnt = 2'b00;
        rd_gnt = 2'b00;
        if (!rst) begin
            wr_gnt = rr_pick(wr_req, wptr);
            rd_gnt = rr_pick(rd_req, rptr);
        end
    end

    assign mem_wr    = |wr_gnt;
    assign mem_waddr = wr_gnt[1] ? rq1.waddr : rq0.waddr;
    assign mem_wdata = wr_gnt[1] ? rq1.wdata : rq0.wdata;
    assign mem_wstrb = wr_gnt[1] ? rq1.wstrb : rq0.wstrb;
    assign mem_rd    = |rd_gnt;
    assign mem_raddr = rd_gnt[1] ? rq1.raddr : rq0.raddr;

    assign rq0.wr_ready = wr_gnt[0];
    assign rq1.wr_ready = wr_gnt[1];
    assign rq0.rd_ready = rd_gnt[0];
    assign rq1.rd_ready = rd_gnt[1];
    assign rq0.rvalid   = head_valid[0];
    assign rq1.rvalid   = head_valid[1];
    assign rq0.rdata    = head_data[0];
    assign rq1.rdata    = head_data[1];

    assign fifo_push[0] = tag_valid && !tag_id;
    assign fifo_push[1] = tag_valid &&  tag_id;

    // NOTE: sequential state is updated with <= only, so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr      <= 1'b1;
            rptr      <= 1'b1;
            tag_valid <= 1'b0;
            tag_id    <= 1'b0;
            credit[0] <= 2'd0;
            credit[1] <= 2'd0;
        end else begin
            if (|wr_gnt) wptr <= wr_gnt[1];
            if (|rd_gnt) rptr <= rd_gnt[1];
            tag_valid <= |rd_gnt;
            tag_id    <= rd_gnt[1];
            for (int n = 0; n < 2; n++) begin
                credit[n] <= credit[n] + {1'b0, rd_gnt[n]} - {1'b0, rd_pop[n]};
            end
        end
    end

    // NOTE: tail_data is storage qualified by tail_valid, so it is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_valid   <= 2'b00;
            tail_valid   <= 2'b00;
            head_data[0] <= '0;
            head_data[1] <= '0;
        end else begin
            for (int n = 0; n < 2; n++) begin
                case ({fifo_push[n], rd_pop[n]})
                    2'b10: begin
                        if (!head_valid[n]) begin
                            head_data[n]  <= mem_rdata;
                            head_valid[n] <= 1'b1;
                        end else begin
                            tail_data[n]  <= mem_rdata;
                            tail_valid[n] <= 1'b1;
                        end
                    end
                    2'b01: begin
                        head_data[n]  <= tail_data[n];
                        head_valid[n] <= tail_valid[n];
                        tail_valid[n] <= 1'b0;
                    end
                    2'b11: begin
                        if (tail_valid[n]) begin
                            head_data[n] <= tail_data[n];
                            tail_data[n] <= mem_rdata;
                        end else begin
                            head_data[n] <= mem_rdata;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
